mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the byte-serial memory bus driven by the core's memory controller.
//   - Backs the bus with byte RAM (1-cycle read latency).
//   - Decodes an IO window holding a TX byte FIFO (core->host) and an RX byte FIFO (host->core).
//   - Drives io_buffer_full so the core can throttle IO stores.
// PARAMETERS
//   RAM_AW       17  RAM address bits; RAM = 2**RAM_AW bytes, index = mem_addr[RAM_AW-1:0]
//   TX_DEPTH_LG  4   log2 TX FIFO depth (16 entries)
//   RX_DEPTH_LG  4   log2 RX FIFO depth (16 entries)
//   INIT_FILE    ""  hex image for $readmemh at elaboration; "" = no load
// PORTS
//   clk             in   1   clock, all state on posedge
//   rst_n           in   1   asynchronous active-low reset
//   rdy             in   1   global ready; 0 = freeze (no write/push/pop, mem_in holds)
//   mem_addr        in   32  byte address from controller
//   mem_rw          in   1   1 = write mem_wdata at mem_addr this cycle, 0 = read
//   mem_wdata       in   8   write byte (controller's mem_out)
//   mem_rdata       out  8   read byte (controller's mem_in), registered
//   io_buffer_full  out  1   TX FIFO free slots < 2, registered
//   tx_data         out  8   TX FIFO head byte
//   tx_valid        out  1   TX FIFO non-empty
//   tx_ready        in   1   host accepts tx_data when tx_valid&&tx_ready
//   rx_data         in   8   byte from host
//   rx_valid        in   1   push rx_data into RX FIFO this cycle
//   sim_halt        out  1   sticky halt flag (see CONFIGURATION)
// BEHAVIOUR
//   - Decode: IO iff mem_addr[17:16]==2'b11, else RAM. Upper RAM bits truncated (wrap).
//   - RAM read: address at edge N -> mem_rdata valid after edge N+1 (1-cycle latency).
//     - Back-to-back addresses stream one byte/cycle.
//   - RAM write: mem_rw=1 && rdy writes on the same edge. mem_rdata updates to RAM[addr] old value.
//   - IO 0x30000 write: push TX. If full with no pop this cycle, byte dropped. Full + pop same cycle: push accepted.
//   - IO 0x30000 read: mem_rdata <= RX head and pop. RX empty: mem_rdata <= 8'h00, no pop.
//     - Destructive; the core must never issue speculative IO reads.
//   - IO 0x30004 read: mem_rdata <= {6'b0, rx_nonempty, tx_full}.
//   - IO 0x30004 write: see CONFIGURATION. Other IO offsets: read 0, write ignored.
//   - FIFOs: circular, ptr width LG+1 (full = MSBs differ, low bits equal).
//     - Simultaneous push+pop: both happen, count unchanged.
//     - RX push when full: dropped. Host pops TX on tx_valid&&tx_ready regardless of rdy.
//   - io_buffer_full: registered from post-update TX count >= DEPTH-1. Deasserts the cycle after a pop frees space.
//   - rdy=0: RAM write, TX push, RX pop and mem_rdata frozen. RX push and TX pop continue (host side).
//   - Reset (async, rst_n=0): mem_rdata=0, io_buffer_full=0, tx_valid=0, tx_data=0, sim_halt=0, all FIFO ptrs=0.
//     - RAM contents untouched. Reset mid-stream discards the in-flight read byte.
// CONFIGURATION
//   MEM_RESP_SIM_HALT_EN defined:
//     - Write to 0x30004 sets sim_halt=1 (sticky until reset).
//     - $display of remaining TX count; $finish after TX drains.
//   Not defined: sim_halt tied 0; write to 0x30004 ignored.
// TESTING
//   1 RAM stream: preload RAM[0x100..0x103]=11,22,33,44; addr 0x100..0x103 one/cycle
//     -> mem_rdata 11,22,33,44 on the following cycles.
//   2 Write/read: write 8'hA5 @0x1FFFF, then read 0x1FFFF -> A5.
//     Read 0x3FFFF (RAM_AW=17 wrap) is IO, not RAM -> 00.
//   3 TX fill: tx_ready=0, 15 writes to 0x30000 -> io_buffer_full=1 after 15th.
//     17th write dropped. tx_ready=1 drains 16 bytes in order.
//   4 RX: host pushes 5A,C3; read 0x30004 -> 02; read 0x30000 twice -> 5A,C3.
//     Third read -> 00, status -> 00.
//   5 rdy=0 during write to 0x30000 and RAM 0x10 -> no TX push, RAM unchanged, mem_rdata held.
//   6 Async reset with TX holding 3 bytes -> tx_valid=0 and mem_rdata=0 before next edge.
//     Halt build: write 0x30004 -> sim_halt=1.

Source files
------------

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the byte-serial memory bus. Backs the bus with
//   a byte RAM (registered read, one cycle of latency) and decodes an IO
//   window (mem_addr[17:16] == 2'b11) that holds:
//     offset 0x0000  write: push TX FIFO (core->host)
//                    read : pop RX FIFO head (host->core), 0 when empty
//     offset 0x0004  read : {6'b0, rx_nonempty, tx_full}
//                    write: sets sim_halt when MEM_RESP_SIM_HALT_EN is defined
//   io_buffer_full tells the core that the TX FIFO has fewer than two free
//   slots, so it can throttle IO stores.
//
// Ports
//   clk, rst_n      clock (posedge) / asynchronous active-low reset
//   rdy             global ready; 0 freezes the core side (RAM write, TX push,
//                   RX pop, mem_rdata). The host side keeps running.
//   mem_addr/mem_rw/mem_wdata  bus request; mem_rdata  registered read byte
//   io_buffer_full  registered TX "almost full"
//   tx_data/tx_valid/tx_ready  TX stream to host
//   rx_data/rx_valid           RX stream from host (no backpressure)
//   sim_halt        sticky halt flag
//
// Handshakes: a TX byte moves on every clock edge where tx_valid && tx_ready,
// independent of rdy; tx_valid never drops without a transfer. RX has no
// ready: a byte offered with rx_valid while the RX FIFO is full is lost.
//
// Build option: define MEM_RESP_SIM_HALT_EN to enable the simulation halt
// register at IO offset 0x0004 (sticky sim_halt, $finish once TX drains).
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int    RAM_AW      = 17,
    parameter int    TX_DEPTH_LG = 4,
    parameter int    RX_DEPTH_LG = 4,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [31:0] mem_addr,
    input  logic        mem_rw,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        sim_halt
);
    localparam int RAM_SIZE = 1 << RAM_AW;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LG;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LG;
    localparam int TXW      = TX_DEPTH_LG + 1;
    localparam int RXW      = RX_DEPTH_LG + 1;

    // ---------------- address decode ----------------
    logic              is_io;
    logic              io_data_sel;
    logic              io_stat_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr;

    assign is_io       = (mem_addr[17:16] == 2'b11);
    assign io_data_sel = is_io && (mem_addr[15:0] == 16'h0000);
    assign io_stat_sel = is_io && (mem_addr[15:0] == 16'h0004);
    // Upper RAM address bits are simply dropped, so RAM aliases (wraps).
    assign ram_idx     = mem_addr[RAM_AW-1:0];
    assign unused_addr = ^mem_addr[31:18];

    // ---------------- RAM (contents survive reset) ----------------
    logic [7:0] ram [0:RAM_SIZE-1];

    always_ff @(posedge clk) begin
        if (rdy && mem_rw && !is_io)
            ram[ram_idx] <= mem_wdata;
    end

    // ---------------- TX FIFO (core -> host) ----------------
    logic [7:0]     tx_mem [0:TX_DEPTH-1];
    logic [TXW-1:0] tx_wr_ptr, tx_rd_ptr, tx_count, tx_count_next;
    logic           tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[TX_DEPTH_LG] != tx_rd_ptr[TX_DEPTH_LG]) &&
                      (tx_wr_ptr[TX_DEPTH_LG-1:0] == tx_rd_ptr[TX_DEPTH_LG-1:0]);
    assign tx_count = tx_wr_ptr - tx_rd_ptr;
    assign tx_pop   = !tx_empty && tx_ready;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is kept.
    assign tx_push  = rdy && mem_rw && io_data_sel && (!tx_full || tx_pop);
    assign tx_count_next = tx_count + TXW'(tx_push) - TXW'(tx_pop);

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr[TX_DEPTH_LG-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr[TX_DEPTH_LG-1:0]] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr      <= '0;
            tx_rd_ptr      <= '0;
            io_buffer_full <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            io_buffer_full <= (tx_count_next >= TXW'(TX_DEPTH - 1));
        end
    end

    // ---------------- RX FIFO (host -> core) ----------------
    logic [7:0]     rx_mem [0:RX_DEPTH-1];
    logic [RXW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic           rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0]     rx_head;

    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[RX_DEPTH_LG] != rx_rd_ptr[RX_DEPTH_LG]) &&
                      (rx_wr_ptr[RX_DEPTH_LG-1:0] == rx_rd_ptr[RX_DEPTH_LG-1:0]);
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = rdy && !mem_rw && io_data_sel && !rx_empty;
    assign rx_head  = rx_mem[rx_rd_ptr[RX_DEPTH_LG-1:0]];

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr[RX_DEPTH_LG-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // ---------------- read data ----------------
    logic [7:0] rdata_next;

    always_comb begin
        rdata_next = 8'h00;
        if (!is_io) begin
            // On a RAM write this returns the byte being overwritten.
            rdata_next = ram[ram_idx];
        end else if (!mem_rw) begin
            if (io_data_sel)
                rdata_next = rx_empty ? 8'h00 : rx_head;
            else if (io_stat_sel)
                rdata_next = {6'b0, !rx_empty, tx_full};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_rdata <= 8'h00;
        else if (rdy)
            mem_rdata <= rdata_next;
    end

    // ---------------- simulation halt ----------------
`ifdef MEM_RESP_SIM_HALT_EN
    logic halt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halt_q <= 1'b0;
        else if (rdy && mem_rw && io_stat_sel)
            halt_q <= 1'b1;
    end

    assign sim_halt = halt_q;

    // Simulation-only: report and stop once the host has drained TX.
    always @(posedge clk) begin
        if (rdy && mem_rw && io_stat_sel && !halt_q)
            $display("mem_responder: halt requested, %0d TX bytes pending", tx_count);
        if (halt_q && tx_empty)
            $finish;
    end
`else
    assign sim_halt = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_rw = 1'b0;
  logic [7:0]  mem_wdata = '0;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        sim_halt;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .sim_halt(sim_halt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: sets the request, lets one edge pass, returns at posedge+1.
  task automatic bus(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
    rdy = r; mem_addr = a; mem_rw = w; mem_wdata = d;
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r;
    logic [31:0] a;
    logic        w;
    logic [7:0]  d;
    logic        rxv;
    logic [7:0]  rxd;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d,
                              input logic rxv, input logic [7:0] rxd, input logic chk, input logic [7:0] exp);
    vec_t v;
    v.r = r; v.a = a; v.w = w; v.d = d; v.rxv = rxv; v.rxd = rxd; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model state ----------------
  logic [7:0] ram_m [int];
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];

  initial begin
    // RAM stream + write/read + wrap into IO
    add(1, 32'h100,   1, 8'h11, 0, 8'h00, 0, 8'h00);
    add(1, 32'h101,   1, 8'h22, 0, 8'h00, 0, 8'h00);
    add(1, 32'h102,   1, 8'h33, 0, 8'h00, 0, 8'h00);
    add(1, 32'h103,   1, 8'h44, 0, 8'h00, 0, 8'h00);
    add(1, 32'h100,   0, 8'h00, 0, 8'h00, 1, 8'h11);
    add(1, 32'h101,   0, 8'h00, 0, 8'h00, 1, 8'h22);
    add(1, 32'h102,   0, 8'h00, 0, 8'h00, 1, 8'h33);
    add(1, 32'h103,   0, 8'h00, 0, 8'h00, 1, 8'h44);
    add(1, 32'h1FFFF, 1, 8'hA5, 0, 8'h00, 0, 8'h00);
    add(1, 32'h1FFFF, 0, 8'h00, 0, 8'h00, 1, 8'hA5);
    add(1, 32'h3FFFF, 0, 8'h00, 0, 8'h00, 1, 8'h00);
    // write returns the old byte
    add(1, 32'h100,   1, 8'h66, 0, 8'h00, 1, 8'h11);
    add(1, 32'h100,   1, 8'h11, 0, 8'h00, 1, 8'h66);
    // RX path
    add(1, 32'h100,   0, 8'h00, 1, 8'h5A, 0, 8'h00);
    add(1, 32'h100,   0, 8'h00, 1, 8'hC3, 0, 8'h00);
    add(1, 32'h30004, 0, 8'h00, 0, 8'h00, 1, 8'h02);
    add(1, 32'h30000, 0, 8'h00, 0, 8'h00, 1, 8'h5A);
    add(1, 32'h30000, 0, 8'h00, 0, 8'h00, 1, 8'hC3);
    add(1, 32'h30000, 0, 8'h00, 0, 8'h00, 1, 8'h00);
    add(1, 32'h30004, 0, 8'h00, 0, 8'h00, 1, 8'h00);
    // rdy=0 freezes writes, pushes and mem_rdata
    add(1, 32'h10,    1, 8'h77, 0, 8'h00, 0, 8'h00);
    add(1, 32'h10,    0, 8'h00, 0, 8'h00, 1, 8'h77);
    add(0, 32'h30000, 1, 8'hEE, 0, 8'h00, 1, 8'h77);
    add(0, 32'h10,    1, 8'h99, 0, 8'h00, 1, 8'h77);
    add(0, 32'h3FFFF, 0, 8'h00, 0, 8'h00, 1, 8'h77);
    add(1, 32'h10,    0, 8'h00, 0, 8'h00, 1, 8'h77);
  end

  // ---------------- test sequence ----------------
  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset mem_rdata", mem_rdata, 0);
    check("reset io_buffer_full", io_buffer_full, 0);
    check("reset tx_valid", tx_valid, 0);
    check("reset tx_data", tx_data, 0);
    check("reset sim_halt", sim_halt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      rx_valid = vecs[i].rxv;
      rx_data  = vecs[i].rxd;
      bus(vecs[i].r, vecs[i].a, vecs[i].w, vecs[i].d);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d mem_rdata", i), mem_rdata, vecs[i].exp);
        check($sformatf("vec%0d tx_valid", i), tx_valid, 0);
      end
    end
    rx_valid = 1'b0;

    // TX fill to full, overflow drop, in-order drain
    tx_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      bus(1, 32'h30000, 1, (i == 17) ? 8'hFF : 8'(i * 7));
      if (i <= DEPTH) exp_q.push_back(8'(i * 7));
      if (i == 14) check("tx fill 14 io_buffer_full", io_buffer_full, 0);
      if (i == 15) check("tx fill 15 io_buffer_full", io_buffer_full, 1);
      if (i == 17) check("tx fill 17 io_buffer_full", io_buffer_full, 1);
    end
    mem_addr = 32'h100; mem_rw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("tx drain %0d valid", i), tx_valid, 1);
      check($sformatf("tx drain %0d data", i), tx_data, e);
      tx_ready = 1'b1;
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    check("tx drained valid", tx_valid, 0);
    check("tx drained io_buffer_full", io_buffer_full, 0);

    // async reset with TX holding 3 bytes
    for (int i = 0; i < 3; i++) bus(1, 32'h30000, 1, 8'(8'hB0 + i));
    bus(1, 32'h100, 0, 8'h00);
    check("pre-reset mem_rdata", mem_rdata, 8'h11);
    check("pre-reset tx_valid", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset tx_valid", tx_valid, 0);
    check("async reset mem_rdata", mem_rdata, 0);
    check("async reset tx_data", tx_data, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus(1, 32'h100, 0, 8'h00);
    check("ram kept over reset", mem_rdata, 8'h11);

    // randomized run against the queue/array model
    begin
      logic [7:0] er;
      bit known;
      er = mem_rdata; known = 1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic [31:0] a;
        logic w, r, tr, rv;
        logic [7:0] d, rd;
        int kind, tsz, rsz;
        bit tpop, tpush, rpop, io;
        r  = ($urandom_range(0, 9) != 0);
        tr = (cyc < 1500) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
        rv = ($urandom_range(0, 2) == 0);
        rd = 8'($urandom);
        d  = 8'($urandom);
        kind = $urandom_range(0, 6);
        w = 0;
        case (kind)
          0, 1: a = 32'h200 + $urandom_range(0, 15);
          2:    begin a = 32'h200 + $urandom_range(0, 15); w = 1; end
          3, 4: begin a = 32'h30000; w = 1; end
          5:    a = 32'h30000;
          default: begin a = ($urandom_range(0, 1) != 0) ? 32'h30004 : 32'h30008; w = (a == 32'h30008) && ($urandom_range(0, 1) != 0); end
        endcase
        a = a | (32'($urandom_range(0, 3)) << 28);

        // model: effects of this edge, from pre-edge occupancy
        tsz = tx_m.size(); rsz = rx_m.size();
        io = (a[17:16] == 2'b11);
        tpop = (tsz > 0) && tr;
        tpush = 0; rpop = 0;
        if (r) begin
          if (!io) begin
            if (ram_m.exists(int'(a[16:0]))) begin er = ram_m[int'(a[16:0])]; known = 1; end
            else known = 0;
            if (w) ram_m[int'(a[16:0])] = d;
          end else if (w) begin
            known = 0;
            if (a[15:0] == 16'h0 && (tsz < DEPTH || tpop)) tpush = 1;
          end else begin
            known = 1;
            if (a[15:0] == 16'h0) begin
              if (rsz > 0) begin er = rx_m[0]; rpop = 1; end
              else er = 8'h00;
            end else if (a[15:0] == 16'h4) er = {6'b0, rsz > 0, tsz == DEPTH};
            else er = 8'h00;
          end
        end
        if (tpop) void'(tx_m.pop_front());
        if (tpush) tx_m.push_back(d);
        if (rpop) void'(rx_m.pop_front());
        if (rv && rsz < DEPTH) rx_m.push_back(rd);

        tx_ready = tr; rx_valid = rv; rx_data = rd;
        bus(r, a, w, d);
        if (known) check($sformatf("rand%0d mem_rdata", cyc), mem_rdata, er);
        check($sformatf("rand%0d tx_valid", cyc), tx_valid, tx_m.size() > 0);
        check($sformatf("rand%0d tx_data", cyc), tx_data, (tx_m.size() > 0) ? tx_m[0] : 8'h00);
        check($sformatf("rand%0d io_buffer_full", cyc), io_buffer_full, tx_m.size() >= DEPTH - 1);
      end
    end
    tx_ready = 1'b0; rx_valid = 1'b0;

    // halt register
    bus(1, 32'h30004, 1, 8'h01);
`ifdef MEM_RESP_SIM_HALT_EN
    check("halt sim_halt", sim_halt, 1);
`else
    check("halt sim_halt", sim_halt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
